// File: rtl/clk_monitor_pkg.sv
// Shared types and default constants for the clock monitor.
//   mon_state_e : monitor FSM states (idle, acquire, measure, fault)
//   Def*        : default parameter values used by clk_monitor
package clk_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StAcquire,
        StMeasure,
        StFault
    } mon_state_e;

    localparam int unsigned DefCntW       = 16;
    localparam int unsigned DefExpPeriod  = 10;
    localparam int unsigned DefTol        = 1;
    localparam int unsigned DefStuckLimit = 64;
    localparam int unsigned DefLockCnt    = 4;

endpackage

// File: rtl/clk_monitor_sync.sv
// Brings the monitored clock into the clk domain and produces one-cycle
// rise/fall pulses. Two synchronizer flops, an edge register, then
// registered pulses: a pulse is high during the third cycle after the
// synchronizer first samples a new mon_clk level.
// Ports:
//   clk_i     : system clock
//   reset_i   : synchronous active-high reset
//   mon_clk_i : asynchronous monitored clock, treated as data
//   rise_o    : one-cycle pulse per mon_clk rising transition
//   fall_o    : one-cycle pulse per mon_clk falling transition
module clk_monitor_sync (
    input  logic clk_i,
    input  logic reset_i,
    input  logic mon_clk_i,
    output logic rise_o,
    output logic fall_o
);

    logic sync1_q, sync2_q, edge_q;
    logic rise_q, fall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= mon_clk_i;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
            rise_q  <= sync2_q & ~edge_q;
            fall_q  <= ~sync2_q & edge_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/clk_monitor.sv
// Clock monitor: measures the period of mon_clk in clk cycles, flags
// out-of-tolerance periods, detects a stuck clock and reports lock after
// LOCK_CNT consecutive good periods.
// Optional feature: define CLK_MONITOR_DUTY_EN to also measure the high
// time (rise-to-fall count); otherwise high_time_o is tied to 0.
// Ports:
//   clk_i          : system clock, all logic on its rising edge
//   reset_i        : synchronous active-high reset
//   mon_clk_i      : monitored clock (asynchronous)
//   enable_i       : measurement enable; low forces idle
//   period_o       : last measured rise-to-rise count
//   high_time_o    : last measured rise-to-fall count (duty build only)
//   period_valid_o : one-cycle pulse when period_o updates
//   period_err_o   : sticky, any period out of tolerance
//   stuck_o        : no mon_clk edge for STUCK_LIMIT cycles
//   locked_o       : LOCK_CNT consecutive good periods seen
module clk_monitor
    import clk_monitor_pkg::*;
#(
    parameter int unsigned CNT_W       = DefCntW,
    parameter int unsigned EXP_PERIOD  = DefExpPeriod,
    parameter int unsigned TOL         = DefTol,
    parameter int unsigned STUCK_LIMIT = DefStuckLimit,
    parameter int unsigned LOCK_CNT    = DefLockCnt
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             mon_clk_i,
    input  logic             enable_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_time_o,
    output logic             period_valid_o,
    output logic             period_err_o,
    output logic             stuck_o,
    output logic             locked_o
);

    localparam int unsigned IdleW = $clog2(STUCK_LIMIT + 1);
    localparam int unsigned LockW = $clog2(LOCK_CNT + 1);
    localparam int unsigned PerLo = (EXP_PERIOD > TOL) ? EXP_PERIOD - TOL : 0;
    localparam int unsigned PerHi = EXP_PERIOD + TOL;
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    logic rise, fall;

    clk_monitor_sync u_sync (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .mon_clk_i (mon_clk_i),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IdleW-1:0] idle_q, idle_d;
    logic [LockW-1:0] good_q, good_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             stuck_q, stuck_d;
    logic             locked_q, locked_d;

    logic idle_hit;
    logic period_good;

    // Next edge-free cycle would reach STUCK_LIMIT.
    assign idle_hit = (idle_q == IdleW'(STUCK_LIMIT - 1));
    // A saturated count is never good, even with a huge tolerance window.
    assign period_good = (cnt_q >= CNT_W'(PerLo)) && (cnt_q <= CNT_W'(PerHi)) &&
                         (cnt_q != CntMax);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idle_d   = idle_q;
        good_d   = good_q;
        period_d = period_q;
        valid_d  = 1'b0;
        err_d    = err_q;
        stuck_d  = stuck_q;
        locked_d = locked_q;

        if (!enable_i) begin
            // Counters and lock drop; measurement outputs hold.
            state_d  = StIdle;
            cnt_d    = '0;
            idle_d   = '0;
            good_d   = '0;
            locked_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StAcquire;
                    stuck_d = 1'b0;
                end
                StAcquire, StMeasure: begin
                    if (state_q == StMeasure && cnt_q != CntMax) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (rise || fall) begin
                        idle_d = '0;
                    end else if (idle_hit) begin
                        state_d  = StFault;
                        stuck_d  = 1'b1;
                        locked_d = 1'b0;
                        good_d   = '0;
                        cnt_d    = '0;
                        idle_d   = '0;
                    end else begin
                        idle_d = idle_q + IdleW'(1);
                    end
                    // Checked after the stuck branch: an edge always wins.
                    if (rise) begin
                        cnt_d = CNT_W'(1);
                        if (state_q == StAcquire) begin
                            state_d = StMeasure;
                        end else begin
                            period_d = cnt_q;
                            valid_d  = 1'b1;
                            if (period_good) begin
                                if (good_q != LockW'(LOCK_CNT)) begin
                                    good_d = good_q + LockW'(1);
                                end
                                if (good_q >= LockW'(LOCK_CNT - 1)) begin
                                    locked_d = 1'b1;
                                end
                            end else begin
                                err_d    = 1'b1;
                                good_d   = '0;
                                locked_d = 1'b0;
                            end
                        end
                    end
                end
                StFault: begin
                    if (rise || fall) begin
                        state_d = StAcquire;
                        stuck_d = 1'b0;
                        idle_d  = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            idle_q   <= '0;
            good_q   <= '0;
            period_q <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            stuck_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idle_q   <= idle_d;
            good_q   <= good_d;
            period_q <= period_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            stuck_q  <= stuck_d;
            locked_q <= locked_d;
        end
    end

`ifdef CLK_MONITOR_DUTY_EN
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] hi_meas_q, hi_meas_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             hi_run_q, hi_run_d;

    always_comb begin
        hi_cnt_d    = hi_cnt_q;
        hi_meas_d   = hi_meas_q;
        high_time_d = high_time_q;
        hi_run_d    = hi_run_q;

        if (!enable_i || state_q == StIdle) begin
            hi_cnt_d = '0;
            hi_run_d = 1'b0;
        end else if (rise) begin
            hi_cnt_d  = CNT_W'(1);
            hi_run_d  = 1'b1;
            // A period without a fall reports 0 high time next time.
            hi_meas_d = '0;
        end else if (hi_run_q) begin
            if (fall) begin
                hi_meas_d = hi_cnt_q;
                hi_run_d  = 1'b0;
            end else if (hi_cnt_q != CntMax) begin
                hi_cnt_d = hi_cnt_q + CNT_W'(1);
            end
        end

        // hi_meas_q still holds the high time of the period just closed.
        if (valid_d) begin
            high_time_d = hi_meas_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hi_cnt_q    <= '0;
            hi_meas_q   <= '0;
            high_time_q <= '0;
            hi_run_q    <= 1'b0;
        end else begin
            hi_cnt_q    <= hi_cnt_d;
            hi_meas_q   <= hi_meas_d;
            high_time_q <= high_time_d;
            hi_run_q    <= hi_run_d;
        end
    end

    assign high_time_o = high_time_q;
`else
    assign high_time_o = '0;
`endif

    assign period_o       = period_q;
    assign period_valid_o = valid_q;
    assign period_err_o   = err_q;
    assign stuck_o        = stuck_q;
    assign locked_o       = locked_q;

endmodule

// File: tb/tb_clk_monitor.sv
module tb_clk_monitor;

    localparam int unsigned CntW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic            mon_clk;
    logic            enable;
    logic [CntW-1:0] period;
    logic [CntW-1:0] high_time;
    logic            period_valid;
    logic            period_err;
    logic            stuck;
    logic            locked;

    clk_monitor #(
        .CNT_W       (CntW),
        .EXP_PERIOD  (10),
        .TOL         (1),
        .STUCK_LIMIT (64),
        .LOCK_CNT    (4)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .mon_clk_i      (mon_clk),
        .enable_i       (enable),
        .period_o       (period),
        .high_time_o    (high_time),
        .period_valid_o (period_valid),
        .period_err_o   (period_err),
        .stuck_o        (stuck),
        .locked_o       (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int lo;
        int per;
        int ht;
        bit err;
        bit lck;
    } vec_t;

    typedef struct {
        int per;
        int ht;
        bit err;
        bit lck;
    } ev_t;

    vec_t tbl[$];
    ev_t  ev_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Every period_valid pulse is logged with the outputs seen alongside it.
    always @(negedge clk) begin
        if (period_valid) begin
            ev_q.push_back('{int'(period), int'(high_time), period_err, locked});
        end
    end

    function automatic int exp_ht(int hi);
`ifdef CLK_MONITOR_DUTY_EN
        return hi;
`else
        return 0;
`endif
    endfunction

    task automatic add(int hi, int lo, int per, bit err, bit lck);
        tbl.push_back('{hi, lo, per, exp_ht(hi), err, lck});
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_ev(string name, int idx, int per, int ht, bit err, bit lck);
        n_vec++;
        if (idx >= ev_q.size()) begin
            n_miss++;
            $display("FAIL %s[%0d]: no period_valid event, expected per=%0d ht=%0d err=%0d lck=%0d",
                     name, idx, per, ht, err, lck);
        end else if (ev_q[idx].per != per || ev_q[idx].ht != ht ||
                     ev_q[idx].err != err || ev_q[idx].lck != lck) begin
            n_miss++;
            $display("FAIL %s[%0d]: got per=%0d ht=%0d err=%0d lck=%0d, expected per=%0d ht=%0d err=%0d lck=%0d",
                     name, idx, ev_q[idx].per, ev_q[idx].ht, ev_q[idx].err, ev_q[idx].lck,
                     per, ht, err, lck);
        end
    endtask

    task automatic drive_period(int hi, int lo);
        mon_clk = 1'b1;
        tick(hi);
        mon_clk = 1'b0;
        tick(lo);
    endtask

    initial begin
        int n0;

        reset   = 1'b1;
        enable  = 1'b0;
        mon_clk = 1'b0;
        tick(3);
        @(negedge clk);
        check("rst_period", int'(period), 0);
        check("rst_high_time", int'(high_time), 0);
        check("rst_flags", int'({period_valid, period_err, stuck, locked}), 0);

        @(posedge clk);
        #1;
        reset  = 1'b0;
        enable = 1'b1;
        tick(3);

        // hi, lo, expected period, err, locked at that period_valid
        add(5, 4,  9, 1'b0, 1'b0);
        add(5, 6, 11, 1'b0, 1'b0);
        add(5, 5, 10, 1'b0, 1'b0);
        add(5, 5, 10, 1'b0, 1'b1);
        add(4, 4,  8, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b1);
        add(6, 6, 12, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b1);
        add(5, 8, 13, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b0);
        add(5, 5, 10, 1'b1, 1'b1);

        // The first rise only acquires; each later rise closes one period.
        foreach (tbl[i]) drive_period(tbl[i].hi, tbl[i].lo);
        mon_clk = 1'b1;
        tick(5);
        check("table_event_count", ev_q.size(), tbl.size());
        foreach (tbl[i]) check_ev("table", i, tbl[i].per, tbl[i].ht, tbl[i].err, tbl[i].lck);

        // Rise pulse lands on the cycle the idle count would reach the limit.
        mon_clk = 1'b0;
        tick(64);
        mon_clk = 1'b1;
        tick(3);
        @(negedge clk);
        check("stuck_before_limit", int'(stuck), 0);
        @(negedge clk);
        check("edge_beats_stuck", int'(stuck), 0);

        // Hold mon_clk low: fall pulse consumed 4 cycles after the change.
        @(posedge clk);
        #1;
        mon_clk = 1'b0;
        tick(67);
        @(negedge clk);
        check("stuck_at_63", int'(stuck), 0);
        @(negedge clk);
        check("stuck_at_64", int'(stuck), 1);
        check("stuck_unlocks", int'(locked), 0);
        check("stuck_keeps_err", int'(period_err), 1);

        // Restart: first rise leaves fault, second rise acquires.
        @(posedge clk);
        #1;
        ev_q.delete();
        for (int i = 0; i < 5; i++) drive_period(5, 5);
        mon_clk = 1'b1;
        tick(6);
        check("stuck_cleared", int'(stuck), 0);
        check("relock_event_count", ev_q.size(), 4);
        for (int i = 0; i < 4; i++) check_ev("relock", i, 10, exp_ht(5), 1'b1, i == 3);

        // Reset 5 cycles after a consumed rise pulse.
        mon_clk = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        check("midrst_period", int'(period), 0);
        check("midrst_flags", int'({period_valid, period_err, stuck, locked}), 0);
        reset = 1'b0;
        ev_q.delete();
        drive_period(5, 5);
        check("no_valid_first_rise", ev_q.size(), 0);
        for (int i = 0; i < 3; i++) drive_period(5, 5);
        mon_clk = 1'b1;
        tick(6);
        check("postrst_event_count", ev_q.size(), 4);
        for (int i = 0; i < 4; i++) check_ev("postrst", i, 10, exp_ht(5), 1'b0, i == 3);

        // Drop enable mid-period.
        enable = 1'b0;
        tick(1);
        check("en_drop_locked", int'(locked), 0);
        check("en_drop_period", int'(period), 10);
        n0 = ev_q.size();
        mon_clk = 1'b0;
        tick(5);
        drive_period(5, 5);
        drive_period(5, 5);
        check("en_drop_no_valid", ev_q.size(), n0);
        check("en_drop_period_hold", int'(period), 10);
        check("en_drop_err_hold", int'(period_err), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/clk_monitor.md
CLK_MONITOR -- requirements
Module: clk_monitor

Interface
REQ-001 Parameter CNT_W, default 16: width of the cycle counters and measurement outputs.
REQ-002 Parameter EXP_PERIOD, default 10: expected mon_clk period, in clk cycles.
REQ-003 Parameter TOL, default 1: allowed |period - EXP_PERIOD|, in clk cycles.
REQ-004 Parameter STUCK_LIMIT, default 64: clk cycles without a mon_clk edge before the clock is declared stuck.
REQ-005 Parameter LOCK_CNT, default 4: consecutive in-tolerance periods required to lock.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 mon_clk  in  1  monitored clock, asynchronous to clk, treated as data.
REQ-009 enable  in  1  measurement enable.
REQ-010 period  out  CNT_W  last measured rise-to-rise count.
REQ-011 high_time  out  CNT_W  last measured rise-to-fall count (CLK_MONITOR_DUTY_EN only, else 0).
REQ-012 period_valid  out  1  one-cycle pulse when period updates.
REQ-013 period_err  out  1  sticky flag: any period out of tolerance.
REQ-014 stuck  out  1  mon_clk has had no edge for STUCK_LIMIT cycles.
REQ-015 locked  out  1  LOCK_CNT consecutive good periods seen.

Function
REQ-016 mon_clk SHALL pass through a 2-flop synchronizer plus an edge register; a rise/fall pulse asserts 3 clk cycles after the sampled mon_clk transition.
REQ-017 FSM states SHALL be IDLE, ACQUIRE, MEASURE and FAULT.
REQ-018 IDLE: enable=1 -> ACQUIRE; from any state, enable=0 -> IDLE next cycle, clearing counters and locked while holding outputs.
REQ-019 ACQUIRE: first rise pulse -> MEASURE with the period counter loaded to 1; no period_valid is emitted.
REQ-020 MEASURE: the counter increments each cycle and saturates at 2^CNT_W-1; on a rise pulse, period <= count, period_valid=1, and the counter reloads to 1.
REQ-021 A period is good iff EXP_PERIOD-TOL <= period <= EXP_PERIOD+TOL, inclusive; a bad period sets period_err, clears the good-run count and deasserts locked.
REQ-022 locked SHALL assert in the same cycle as the period_valid of the LOCK_CNT-th consecutive good period; the good-run counter saturates at LOCK_CNT.
REQ-023 Idle counter: reset on any edge pulse; reaching STUCK_LIMIT in ACQUIRE or MEASURE -> FAULT, stuck=1, locked=0.
REQ-024 FAULT: the next edge pulse clears stuck and goes to ACQUIRE; period_err stays set.
REQ-025 A saturated period count SHALL be reported as the saturated value and counts as bad.
REQ-026 A simultaneous rise pulse and stuck threshold SHALL resolve with the edge winning, with no FAULT entry.
REQ-027 period_err SHALL clear only on reset.

Reset
REQ-028 On reset, all outputs SHALL be 0, the FSM SHALL be IDLE, and the counters and synchronizer flops SHALL be 0.
REQ-029 Reset mid-measurement SHALL discard the partial count, and the first period after reset SHALL again require ACQUIRE.

Configuration
REQ-030 Macro CLK_MONITOR_DUTY_EN defined: a high-time counter SHALL run from each rise pulse to the following fall pulse, and high_time SHALL update together with period_valid.
REQ-031 Macro CLK_MONITOR_DUTY_EN undefined: the high-time counter SHALL be absent and high_time SHALL be tied to 0.

Structure
REQ-032 Package clk_monitor_pkg SHALL hold the FSM state typedef (IDLE, ACQUIRE, MEASURE, FAULT) and default parameter constants.
REQ-033 Sub-module clk_monitor_sync SHALL contain the 2-flop synchronizer and edge detector, outputting rise and fall pulses.

Verification
REQ-034 Scenario: mon_clk period 10 clk, 50% duty, enable=1 -> period=10 on each period_valid, high_time=5 (DUTY_EN), and locked=1 at the 4th valid.
REQ-035 Scenario: after lock, one mon_clk period of 13 clk -> period=13, period_err=1, locked=0; locked reasserts after 4 further 10-cycle periods, while period_err stays 1.
REQ-036 Scenario: mon_clk held at 0 after lock -> stuck=1 exactly 64 clk after the last edge pulse; restarting mon_clk -> stuck=0, ACQUIRE, relock.
REQ-037 Scenario: periods of 9 and 11 -> both good, no period_err; periods of 8 and 12 -> period_err=1.
REQ-038 Scenario: reset pulsed 5 clk after a rise pulse -> all outputs 0, and no period_valid until the second rise after reset.
REQ-039 Scenario: enable dropped mid-period -> IDLE, no period_valid, period holds its last value, locked=0.
